// File: rtl/osd_diag_event_arbiter.sv
// Round-robin arbiter that serialises diagnosis events from NUM_SRC monitors
// into DII event packets (dest, src, type, ts_lo, ts_hi, payload words).
package osd_diag_event_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_diag_event_arbiter
  import osd_diag_event_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned PAYLOAD_FLITS = 4,
  parameter int unsigned TS_WIDTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [9:0]                          id,
  input  logic [15:0]                         event_dest,
  input  logic                                enable,
  input  logic [TS_WIDTH-1:0]                 timestamp,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_SRC*PAYLOAD_FLITS*16-1:0] src_data,
  output dii_flit                             debug_out,
  input  logic                                debug_out_ready,
  output logic                                busy,
  output logic [2:0]                          granted
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned PAY_W  = PAYLOAD_FLITS * WORD_W;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEST    = 3'd1,
    S_SRC     = 3'd2,
    S_TYPE    = 3'd3,
    S_TS_LO   = 3'd4,
    S_TS_HI   = 3'd5,
    S_PAYLOAD = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_granted;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [PAY_W-1:0]     r_pay;
  logic [2:0]           r_word;

  logic [IDX_W-1:0]     w_sel;
  logic                 w_found;
  logic                 w_grant;
  logic [NUM_SRC-1:0]   w_ready;
  logic [PAY_W-1:0]     w_sel_data;
  logic                 w_last;
  logic                 w_accept;

  // Round-robin search: first pass above the pointer, second pass wraps from 0.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!w_found && src_valid[i] && (IDX_W'(i) > r_ptr)) begin
        w_sel   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!w_found && src_valid[i]) begin
        w_sel   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  // Reset gates the grant so no accept pulse leaks out while rst is low.
  assign w_grant = rst && enable && w_found && (r_state == S_IDLE);

  always_comb begin
    w_ready    = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_ready[i] = w_grant;
        w_sel_data = src_data[i*PAY_W +: PAY_W];
      end
    end
  end

  assign w_last   = (r_state == S_PAYLOAD) && (r_word == 3'(PAYLOAD_FLITS - 1));
  assign w_accept = debug_out.valid && debug_out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_grant)  w_state_nxt = S_DEST;
      S_DEST:    if (w_accept) w_state_nxt = S_SRC;
      S_SRC:     if (w_accept) w_state_nxt = S_TYPE;
      S_TYPE:    if (w_accept) w_state_nxt = S_TS_LO;
      S_TS_LO:   if (w_accept) w_state_nxt = S_TS_HI;
      S_TS_HI:   if (w_accept) w_state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (w_accept && w_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    debug_out = '0;
    busy      = w_grant;
    unique case (r_state)
      S_IDLE: ;
      S_DEST: begin
        debug_out.valid = 1'b1;
        debug_out.data  = event_dest;
      end
      S_SRC: begin
        debug_out.valid = 1'b1;
        debug_out.data  = {6'b0, id};
      end
      S_TYPE: begin
        debug_out.valid = 1'b1;
        debug_out.data  = {2'b10, 11'b0, r_granted};
      end
      S_TS_LO: begin
        debug_out.valid = 1'b1;
        debug_out.data  = r_ts[15:0];
      end
      S_TS_HI: begin
        debug_out.valid = 1'b1;
        debug_out.data  = r_ts[31:16];
      end
      S_PAYLOAD: begin
        debug_out.valid = 1'b1;
        debug_out.last  = w_last;
        debug_out.data  = r_pay[WORD_W-1:0];
      end
      default: ;
    endcase
    if (r_state != S_IDLE) busy = 1'b1;
    src_ready = w_ready;
    granted   = r_granted;
  end

  // Event latch; payload is shifted down so the current word is always in the LSBs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= IDX_W'(NUM_SRC - 1);
      r_granted <= '0;
      r_ts      <= '0;
      r_pay     <= '0;
      r_word    <= '0;
    end else if (w_grant) begin
      r_ptr     <= w_sel;
      r_granted <= w_sel;
      r_ts      <= timestamp;
      r_pay     <= w_sel_data;
      r_word    <= '0;
    end else if (w_accept && (r_state == S_PAYLOAD)) begin
      r_pay  <= r_pay >> WORD_W;
      r_word <= r_word + 3'd1;
    end
  end

endmodule
